// File: rtl/triangle_dispatcher_if.sv
// triangle_dispatcher_if: upstream FIFO handshake plus shared unit payload bus.
// master drives triangles and unit readiness; slave is the dispatcher.
interface triangle_dispatcher_if #(
    parameter int NUM_UNITS = 4
);
    logic                 valid_in;
    logic                 ready_out;
    logic [3:0][31:0]     position_in;
    logic [2:0][31:0]     normal_in;
    logic [11:0]          material_in;
    logic [NUM_UNITS-1:0] unit_valid_out;
    logic [NUM_UNITS-1:0] unit_ready_in;
    logic [3:0][31:0]     position_out;
    logic [2:0][31:0]     normal_out;
    logic [11:0]          material_out;

    modport master (
        output valid_in,
        output position_in,
        output normal_in,
        output material_in,
        output unit_ready_in,
        input  ready_out,
        input  unit_valid_out,
        input  position_out,
        input  normal_out,
        input  material_out
    );

    modport slave (
        input  valid_in,
        input  position_in,
        input  normal_in,
        input  material_in,
        input  unit_ready_in,
        output ready_out,
        output unit_valid_out,
        output position_out,
        output normal_out,
        output material_out
    );
endinterface

// File: rtl/triangle_dispatcher.sv
// triangle_dispatcher: credit-based round-robin dispatch of triangles to units.
// Optional stall statistics counter is built when DISPATCH_STATS_EN is defined.
module triangle_dispatcher #(
    parameter int NUM_UNITS = 4,
    parameter int CREDITS   = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    triangle_dispatcher_if.slave bus,
    input  logic [NUM_UNITS-1:0] unit_done_in,
    output logic                 idle_out,
    output logic                 credit_err_out,
    output logic [31:0]          stall_count_out
);
    localparam int IW = $clog2(NUM_UNITS);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CFULL = CW'(CREDITS);
    localparam logic [IW-1:0] ULAST = IW'(NUM_UNITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SEND} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [IW-1:0]    pick, idx;
    logic [CW-1:0]    credit_q [NUM_UNITS];
    logic [CW-1:0]    credit_d [NUM_UNITS];
    logic [3:0][31:0] pos_q;
    logic [2:0][31:0] nrm_q;
    logic [11:0]      mat_q;
    logic             idle_q, idle_d;
    logic             err_q, err_d;
    logic             found, load, fire;

    // Walk from rr_ptr upward; lowest offset with a credit wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_q) + k) % NUM_UNITS);
            if (credit_q[idx] != '0) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        load    = 1'b0;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.valid_in) begin
                    load    = 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (found) begin
                    grant_d = pick;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.unit_ready_in[grant_q]) begin
                    fire    = 1'b1;
                    rr_d    = (grant_q == ULAST) ? '0 : grant_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A done and a dispatch on the same unit cancel out.
    always_comb begin
        err_d  = err_q;
        idle_d = (state_d == S_IDLE);
        for (int i = 0; i < NUM_UNITS; i++) begin
            credit_d[i] = credit_q[i];
            if (unit_done_in[i] && !(fire && grant_q == IW'(i))) begin
                if (credit_q[i] == CFULL) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + 1'b1;
                end
            end else if (!unit_done_in[i] && fire &&
                         grant_q == IW'(i) && credit_q[i] != '0) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end
            if (credit_d[i] != CFULL) begin
                idle_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            pos_q   <= '0;
            nrm_q   <= '0;
            mat_q   <= '0;
            idle_q  <= 1'b1;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                credit_q[i] <= CFULL;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            if (load) begin
                pos_q <= bus.position_in;
                nrm_q <= bus.normal_in;
                mat_q <= bus.material_in;
            end
            for (int i = 0; i < NUM_UNITS; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] stall_q;
    logic        stall;

    assign stall = (state_q == S_SELECT && !found) ||
                   (state_q == S_SEND && !bus.unit_ready_in[grant_q]);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_q <= '0;
        end else if (stall && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count_out = stall_q;
`else
    assign stall_count_out = '0;
`endif

    assign bus.ready_out      = (state_q == S_IDLE);
    assign bus.unit_valid_out = (state_q == S_SEND) ?
                                (NUM_UNITS'(1) << grant_q) : '0;
    assign bus.position_out   = pos_q;
    assign bus.normal_out     = nrm_q;
    assign bus.material_out   = mat_q;
    assign idle_out           = idle_q;
    assign credit_err_out     = err_q;
endmodule

// File: tb/tb_triangle_dispatcher.sv
// tb_triangle_dispatcher: directed scenarios plus randomized traffic
// checked against a transaction-level credit/round-robin model.
`timescale 1ns/1ps
module tb_triangle_dispatcher;
    localparam int N = 4;
    localparam int C = 2;
`ifdef DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] done;
    logic         idle;
    logic         err;
    logic [31:0]  stall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_acc = 0;
    int pulse_cyc = 0;

    // reference model state
    int               mcred [N];
    int               mrr, mstate, mgrant, nstate, dec_u, g, mstall;
    logic [11:0]      pend_mat;
    logic [3:0][31:0] pend_pos;
    logic [2:0][31:0] pend_nrm;
    logic [N-1:0]     exp_uv, d;
    logic             all_full;

    triangle_dispatcher_if #(.NUM_UNITS(N)) bus ();

    triangle_dispatcher #(.NUM_UNITS(N), .CREDITS(C)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .bus             (bus.slave),
        .unit_done_in    (done),
        .idle_out        (idle),
        .credit_err_out  (err),
        .stall_count_out (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [3:0][31:0] pos_of(input logic [11:0] m);
        logic [3:0][31:0] r;
        for (int j = 0; j < 4; j++) r[j] = {8'(j + 1), 12'h0, m};
        return r;
    endfunction

    function automatic logic [2:0][31:0] nrm_of(input logic [11:0] m);
        logic [2:0][31:0] r;
        for (int j = 0; j < 3; j++) r[j] = {8'(j + 8'h20), 12'h5, m};
        return r;
    endfunction

    task automatic do_reset();
        rst_n             = 1'b0;
        bus.valid_in      = 1'b0;
        bus.unit_ready_in = '0;
        done              = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [11:0] m);
        int n = 0;
        while (!bus.ready_out && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", bus.ready_out, 1'b1);
        bus.valid_in    = 1'b1;
        bus.material_in = m;
        bus.position_in = pos_of(m);
        bus.normal_in   = nrm_of(m);
        prev_acc        = acc_cyc;
        acc_cyc         = cyc;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_offer(input string tag, input logic [N-1:0] oh,
                              input int lat, input logic [11:0] m);
        int n = 0;
        while (bus.unit_valid_out == '0 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_onehot"}, bus.unit_valid_out, oh);
        check({tag, "_lat"}, cyc - acc_cyc, lat);
        check({tag, "_mat"}, bus.material_out, m);
        check({tag, "_pos"}, bus.position_out, pos_of(m));
        check({tag, "_nrm"}, bus.normal_out, nrm_of(m));
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.valid_in      = 1'b0;
        bus.unit_ready_in = '0;
        bus.material_in   = '0;
        bus.position_in   = '0;
        bus.normal_in     = '0;
        done              = '0;
        #12;
        check("rst_ready", bus.ready_out, 1'b1);
        check("rst_uvalid", bus.unit_valid_out, '0);
        check("rst_idle", idle, 1'b1);
        check("rst_err", err, 1'b0);
        check("rst_stall", stall, 0);
        check("rst_mat", bus.material_out, 0);
        check("rst_pos", bus.position_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // round robin, back-to-back
        bus.unit_ready_in = '1;
        for (int k = 0; k < 5; k++) begin
            send(12'(k + 1));
            if (k > 0) check("rr_tput", acc_cyc - prev_acc, 3);
            wait_offer("rr", N'(1) << (k % N), 2, 12'(k + 1));
            tick();
        end
        done = '1;
        tick();
        done = '0;
        check("multi_done_idle", idle, 1'b0);
        done = 4'b0001;
        tick();
        done = '0;
        check("restore_idle", idle, 1'b1);

        // credit exhaustion, rr_ptr now 1
        for (int k = 0; k < 8; k++) begin
            send(12'h10 + 12'(k));
            wait_offer("exh", N'(1) << ((k + 1) % N), 2, 12'h10 + 12'(k));
            tick();
        end
        send(12'h0AB);
        for (int j = 0; j < 5; j++) begin
            check("exh_wait_uv", bus.unit_valid_out, '0);
            check("exh_wait_rdy", bus.ready_out, 1'b0);
            tick();
        end
        done    = 4'b0100;
        acc_cyc = cyc;
        tick();
        done = '0;
        wait_offer("exh9", 4'b0100, 2, 12'h0AB);
        tick();
        done = '1;
        tick();
        tick();
        done = '0;
        check("exh_err", err, 1'b0);
        check("exh_idle", idle, 1'b1);

        // reset while offering, rr_ptr now 3
        bus.unit_ready_in = '0;
        send(12'h0CC);
        wait_offer("rstsend", 4'b1000, 2, 12'h0CC);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstsend_uv", bus.unit_valid_out, '0);
        check("rstsend_rdy", bus.ready_out, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rstsend_idle", idle, 1'b1);
        check("rstsend_mat", bus.material_out, 0);

        // backpressure on unit 1
        bus.unit_ready_in = 4'b1101;
        send(12'h0E1);
        wait_offer("bp0", 4'b0001, 2, 12'h0E1);
        tick();
        send(12'h0E2);
        wait_offer("bp1", 4'b0010, 2, 12'h0E2);
        for (int j = 0; j < 10; j++) begin
            check("bp_uv", bus.unit_valid_out, 4'b0010);
            check("bp_mat", bus.material_out, 12'h0E2);
            check("bp_pos", bus.position_out, pos_of(12'h0E2));
            check("bp_rdy", bus.ready_out, 1'b0);
            tick();
        end
        bus.unit_ready_in = '1;
        check("bp_stall", stall, STATS ? 10 : 0);
        check("bp_uv_last", bus.unit_valid_out, 4'b0010);
        tick();
        check("bp_drop", bus.unit_valid_out, '0);

        // same-cycle dispatch and done on unit 0
        do_reset();
        send(12'h0F1);
        wait_offer("sim", 4'b0001, 2, 12'h0F1);
        bus.unit_ready_in = 4'b0001;
        done              = 4'b0001;
        tick();
        done              = '0;
        bus.unit_ready_in = '1;
        check("sim_err", err, 1'b0);
        check("sim_idle", idle, 1'b1);
        send(12'h0F2);
        wait_offer("sim_rr", 4'b0010, 2, 12'h0F2);
        tick();

        // credit error is sticky
        done = 4'b0010;
        tick();
        done = '0;
        check("err_clean", err, 1'b0);
        done = 4'b1000;
        tick();
        done = '0;
        check("err_set", err, 1'b1);
        check("err_idle", idle, 1'b1);
        tick();
        tick();
        tick();
        check("err_sticky", err, 1'b1);
        check("err_idle2", idle, 1'b1);

        // randomized traffic against the model
        do_reset();
        mrr      = 0;
        mstate   = 0;
        mgrant   = 0;
        mstall   = 0;
        pend_mat = '0;
        pend_pos = '0;
        pend_nrm = '0;
        for (int i = 0; i < N; i++) mcred[i] = C;
        for (int t = 0; t < 3000; t++) begin
            exp_uv   = (mstate == 2) ? (N'(1) << mgrant) : '0;
            all_full = 1'b1;
            for (int i = 0; i < N; i++) if (mcred[i] != C) all_full = 1'b0;
            check("r_uv", bus.unit_valid_out, exp_uv);
            check("r_rdy", bus.ready_out, mstate == 0);
            check("r_idle", idle, (mstate == 0) && all_full);
            check("r_err", err, 1'b0);
            check("r_stall", stall, STATS ? mstall : 0);
            check("r_mat", bus.material_out, pend_mat);
            check("r_pos", bus.position_out, pend_pos);
            check("r_nrm", bus.normal_out, pend_nrm);

            bus.valid_in      = 1'($urandom_range(0, 1));
            bus.material_in   = 12'($urandom);
            for (int j = 0; j < 4; j++) bus.position_in[j] = $urandom;
            for (int j = 0; j < 3; j++) bus.normal_in[j] = $urandom;
            bus.unit_ready_in = N'($urandom);
            for (int i = 0; i < N; i++)
                d[i] = (mcred[i] < C) && ($urandom_range(0, 7) == 0);
            done = d;

            nstate = mstate;
            dec_u  = -1;
            if (mstate == 0) begin
                if (bus.valid_in) begin
                    nstate   = 1;
                    pend_mat = bus.material_in;
                    pend_pos = bus.position_in;
                    pend_nrm = bus.normal_in;
                end
            end else if (mstate == 1) begin
                g = -1;
                for (int k = 0; k < N && g < 0; k++)
                    if (mcred[(mrr + k) % N] > 0) g = (mrr + k) % N;
                if (g >= 0) begin
                    mgrant = g;
                    nstate = 2;
                end else begin
                    mstall++;
                end
            end else begin
                if (bus.unit_ready_in[mgrant]) begin
                    dec_u  = mgrant;
                    mrr    = (mgrant + 1) % N;
                    nstate = 0;
                end else begin
                    mstall++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (d[i]) mcred[i]++;
                if (i == dec_u) mcred[i]--;
            end
            mstate = nstate;
            tick();
        end
        done = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
